// File: rtl/dsp_result_drain_pkg.sv
// Shared DSP48A1 datapath constants and small helpers for the result drain.
package dsp_result_drain_pkg;

    localparam int unsigned P_WIDTH     = 48;
    localparam int unsigned MAX_LATENCY = 8;
    localparam int unsigned FIFO_DEPTH  = 2;

    typedef logic [1:0] fifo_cnt_t;

    function automatic logic fifo_full(input fifo_cnt_t cnt);
        return cnt == fifo_cnt_t'(FIFO_DEPTH);
    endfunction

endpackage

// File: rtl/dsp_result_drain_res_fifo2.sv
// Two-entry in-order result buffer; pointers wrap modulo 2.
module res_fifo2
    import dsp_result_drain_pkg::*;
#(
    parameter int unsigned W = P_WIDTH + 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] wdata_i,
    output logic [W-1:0] rdata_o,
    output fifo_cnt_t    count_o
);

    logic [W-1:0] mem_q [FIFO_DEPTH];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    fifo_cnt_t    cnt_q;
    fifo_cnt_t    cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            cnt_q <= cnt_d;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/dsp_result_drain.sv
// DSP48A1 consumer-side drain: tracks samples in flight, drives the shared
// clock-enable and hands P/CARRYOUT results downstream over valid/ready.
module dsp_result_drain
    import dsp_result_drain_pkg::*;
#(
    parameter int unsigned WIDTH   = P_WIDTH,
    parameter int unsigned LATENCY = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ce,
    input  logic [WIDTH-1:0] p_in,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic             busy
);

    if (LATENCY < 1 || LATENCY > MAX_LATENCY) begin : g_bad_latency
        $error("dsp_result_drain: LATENCY out of range 1..MAX_LATENCY");
    end

    logic [LATENCY-1:0] vld_q;
    logic [LATENCY-1:0] vld_d;
    logic               vld_last;
    logic               push;
    logic               pop;
    fifo_cnt_t          fifo_cnt;
    logic [WIDTH:0]     head;

    assign vld_last = vld_q[LATENCY-1];

    // ce uses only registered state plus reset, so out_ready never reaches it
    // combinationally; the second FIFO slot absorbs the result that is already
    // at p_in when the stall begins.
    assign ce       = rst && (!fifo_full(fifo_cnt) || !vld_last);
    assign in_ready = ce;
    assign push     = ce && vld_last;
    assign pop      = out_valid && out_ready;

    always_comb begin
        vld_d = vld_q;
        if (ce) begin
            vld_d[0] = in_valid;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                vld_d[i] = vld_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    res_fifo2 #(
        .W(WIDTH + 1)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({carry_in, p_in}),
        .rdata_o (head),
        .count_o (fifo_cnt)
    );

    assign {out_carry, out_data} = head;
    assign out_valid             = (fifo_cnt != '0);
    assign busy                  = (|vld_q) || out_valid;

endmodule
